// File: rtl/sram_like_pkg.sv
// Shared types and constants for the sram-like arbiter slice.
package sram_like_pkg;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// One sram-like request/response channel; the requester side uses master.
interface sram_like_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_arb_pick.sv
// Combinational candidate select. SRAM_LIKE_ARB_RR_EN turns the tie rule
// into round-robin against last_owner; otherwise data always wins a tie.
module sram_like_arb_pick
    import sram_like_pkg::*;
(
    input  logic   inst_req,
    input  logic   data_req,
    input  owner_t last_owner,
    output owner_t cand
);
    owner_t tie_winner;

`ifdef SRAM_LIKE_ARB_RR_EN
    assign tie_winner = (last_owner == OWN_DATA) ? OWN_INST : OWN_DATA;
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
    assign tie_winner        = OWN_DATA;
`endif

    always_comb begin
        cand = OWN_INST;
        if (data_req && !inst_req) begin
            cand = OWN_DATA;
        end else if (inst_req && data_req) begin
            cand = tie_winner;
        end
    end
endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like master port between inst and data requesters, one
// transaction at a time. Widths come from the connected interfaces.
// Optional round-robin tie rule: SRAM_LIKE_ARB_RR_EN (see sram_like_arb_pick).
module sram_like_arbiter
    import sram_like_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    sram_like_arbiter_if.slave   inst,
    sram_like_arbiter_if.slave   data,
    sram_like_arbiter_if.master  m,
    output logic                 busy
);
    arb_state_t state, state_nxt;
    owner_t     owner, last_owner, cand;
    logic       any_req, accept;

    sram_like_arb_pick u_pick (
        .inst_req   (inst.req),
        .data_req   (data.req),
        .last_owner (last_owner),
        .cand       (cand)
    );

    assign any_req = inst.req | data.req;
    assign accept  = (state == ARB_IDLE) && any_req && m.addr_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            owner      <= OWN_INST;
            last_owner <= OWN_INST;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner      <= cand;
                last_owner <= cand;
            end
        end
    end

    // Responses seen in IDLE and accepts seen in WAIT never move the state.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (accept)    state_nxt = ARB_WAIT;
            ARB_WAIT: if (m.data_ok) state_nxt = ARB_IDLE;
            default:                 state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        m.req        = 1'b0;
        m.wr         = (cand == OWN_DATA) ? data.wr    : inst.wr;
        m.size       = (cand == OWN_DATA) ? data.size  : inst.size;
        m.addr       = (cand == OWN_DATA) ? data.addr  : inst.addr;
        m.wdata      = (cand == OWN_DATA) ? data.wdata : inst.wdata;
        inst.addr_ok = 1'b0;
        data.addr_ok = 1'b0;
        inst.data_ok = 1'b0;
        data.data_ok = 1'b0;
        inst.rdata   = m.rdata;
        data.rdata   = m.rdata;
        busy         = 1'b0;
        if (!rst) begin
            case (state)
                ARB_IDLE: begin
                    m.req = any_req;
                    if (cand == OWN_DATA) data.addr_ok = m.addr_ok;
                    else                  inst.addr_ok = m.addr_ok;
                end
                ARB_WAIT: begin
                    busy = 1'b1;
                    if (owner == OWN_DATA) data.data_ok = m.data_ok;
                    else                   inst.data_ok = m.data_ok;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed plus random checks of sram_like_arbiter against a reference model
// that tracks only the outstanding owner and the last granted side.
module tb_sram_like_arbiter;
    import sram_like_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_bus ();
    sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_bus ();
    sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m_bus ();

    sram_like_arbiter dut (
        .clk  (clk),
        .rst  (rst),
        .inst (inst_bus.slave),
        .data (data_bus.slave),
        .m    (m_bus.master),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: pend = -1 when nothing outstanding, else 0 (inst) / 1 (data).
    int pend = -1;
    int last = 0;

    logic obs_iaok, obs_daok, obs_idok, obs_ddok, obs_busy, obs_mreq;
    logic [31:0] obs_maddr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic ir, input logic dr);
        if (ir && dr) begin
`ifdef SRAM_LIKE_ARB_RR_EN
            return (last == 1) ? 0 : 1;
`else
            return 1;
`endif
        end
        return dr ? 1 : 0;
    endfunction

    // Called just after a rising edge; checks mid-cycle, then steps the model.
    task automatic cycle();
        int   cand;
        logic any;
        #2;
        any  = inst_bus.req | data_bus.req;
        cand = pick(inst_bus.req, data_bus.req);
        obs_iaok = inst_bus.addr_ok; obs_daok = data_bus.addr_ok;
        obs_idok = inst_bus.data_ok; obs_ddok = data_bus.data_ok;
        obs_busy = busy; obs_mreq = m_bus.req; obs_maddr = m_bus.addr;
        chk("inst_rdata", inst_bus.rdata, m_bus.rdata);
        chk("data_rdata", data_bus.rdata, m_bus.rdata);
        if (rst || pend < 0) begin
            chk("inst_data_ok", {31'd0, obs_idok}, 32'd0);
            chk("data_data_ok", {31'd0, obs_ddok}, 32'd0);
            chk("busy", {31'd0, obs_busy}, 32'd0);
        end
        if (rst) begin
            chk("m_req_rst", {31'd0, obs_mreq}, 32'd0);
            chk("inst_addr_ok_rst", {31'd0, obs_iaok}, 32'd0);
            chk("data_addr_ok_rst", {31'd0, obs_daok}, 32'd0);
        end else if (pend < 0) begin
            chk("m_req", {31'd0, obs_mreq}, {31'd0, any});
            if (any) begin
                chk("inst_addr_ok", {31'd0, obs_iaok}, (cand == 0) ? {31'd0, m_bus.addr_ok} : 32'd0);
                chk("data_addr_ok", {31'd0, obs_daok}, (cand == 1) ? {31'd0, m_bus.addr_ok} : 32'd0);
                chk("m_wr", {31'd0, m_bus.wr}, {31'd0, (cand == 1) ? data_bus.wr : inst_bus.wr});
                chk("m_size", {30'd0, m_bus.size}, {30'd0, (cand == 1) ? data_bus.size : inst_bus.size});
                chk("m_addr", obs_maddr, (cand == 1) ? data_bus.addr : inst_bus.addr);
                chk("m_wdata", m_bus.wdata, (cand == 1) ? data_bus.wdata : inst_bus.wdata);
            end
        end else begin
            chk("m_req_wait", {31'd0, obs_mreq}, 32'd0);
            chk("inst_addr_ok_wait", {31'd0, obs_iaok}, 32'd0);
            chk("data_addr_ok_wait", {31'd0, obs_daok}, 32'd0);
            chk("busy_wait", {31'd0, obs_busy}, 32'd1);
            chk("inst_data_ok_wait", {31'd0, obs_idok}, (pend == 0) ? {31'd0, m_bus.data_ok} : 32'd0);
            chk("data_data_ok_wait", {31'd0, obs_ddok}, (pend == 1) ? {31'd0, m_bus.data_ok} : 32'd0);
        end
        @(posedge clk);
        if (rst) begin
            pend = -1; last = 0;
        end else if (pend < 0 && any && m_bus.addr_ok) begin
            pend = cand; last = cand;
        end else if (pend >= 0 && m_bus.data_ok) begin
            pend = -1;
        end
        #1;
    endtask

    task automatic set_inst(input logic rq, input logic [31:0] a);
        inst_bus.req = rq; inst_bus.wr = 1'b0; inst_bus.size = SZ_WORD;
        inst_bus.addr = a; inst_bus.wdata = 32'h0;
    endtask

    task automatic set_data(input logic rq, input logic w, input logic [31:0] a, input logic [31:0] wd);
        data_bus.req = rq; data_bus.wr = w; data_bus.size = SZ_WORD;
        data_bus.addr = a; data_bus.wdata = wd;
    endtask

    task automatic set_m(input logic aok, input logic dok, input logic [31:0] rd);
        m_bus.addr_ok = aok; m_bus.data_ok = dok; m_bus.rdata = rd;
    endtask

    initial begin
        int  busy_cnt;
        logic [3:0] grants;
        logic [3:0] exp_grants;
        rst = 1'b1;
        set_inst(1'b0, 32'h0); set_data(1'b0, 1'b0, 32'h0, 32'h0); set_m(1'b0, 1'b0, 32'hA5A5A5A5);
        @(posedge clk); #1;
        // Reset state, with requests and master handshakes active
        set_inst(1'b1, 32'h100); set_m(1'b1, 1'b1, 32'h5A5A5A5A);
        cycle(); cycle();
        rst = 1'b0;
        set_inst(1'b0, 32'h0); set_m(1'b0, 1'b0, 32'h0);
        cycle();

        // Inst only
        busy_cnt = 0;
        set_inst(1'b1, 32'hBFC00000); set_m(1'b1, 1'b0, 32'h0);
        cycle();
        chk("t1_inst_addr_ok", {31'd0, obs_iaok}, 32'd1);
        set_inst(1'b0, 32'h0); set_m(1'b0, 1'b0, 32'h0);
        cycle(); busy_cnt += int'(obs_busy);
        set_m(1'b0, 1'b1, 32'h24010001);
        cycle(); busy_cnt += int'(obs_busy);
        chk("t1_inst_data_ok", {31'd0, obs_idok}, 32'd1);
        chk("t1_data_data_ok", {31'd0, obs_ddok}, 32'd0);
        set_m(1'b0, 1'b0, 32'h0);
        cycle(); busy_cnt += int'(obs_busy);
        chk("t1_busy_cycles", busy_cnt, 32'd2);

        // Tie: data store wins, inst follows one cycle after data_data_ok
        set_inst(1'b1, 32'hBFC00004); set_data(1'b1, 1'b1, 32'h80000010, 32'hDEADBEEF);
        set_m(1'b1, 1'b0, 32'h0);
        cycle();
        chk("t2_data_addr_ok", {31'd0, obs_daok}, 32'd1);
        chk("t2_inst_addr_ok", {31'd0, obs_iaok}, 32'd0);
        chk("t2_m_addr", obs_maddr, 32'h80000010);
        set_data(1'b0, 1'b0, 32'h0, 32'h0); set_m(1'b0, 1'b1, 32'h0);
        cycle();
        chk("t2_data_data_ok", {31'd0, obs_ddok}, 32'd1);
        set_m(1'b1, 1'b0, 32'h0);
        cycle();
        chk("t2_inst_next", {31'd0, obs_iaok}, 32'd1);
        set_inst(1'b0, 32'h0); set_m(1'b0, 1'b1, 32'h11111111);
        cycle();

        // Four back-to-back ties
        set_inst(1'b1, 32'hBFC00008); set_data(1'b1, 1'b0, 32'h80000020, 32'h0);
        for (int k = 0; k < 4; k++) begin
            set_m(1'b1, 1'b0, 32'h0);
            cycle();
            grants[k] = obs_daok;
            set_m(1'b0, 1'b1, 32'h1000 + k);
            cycle();
        end
`ifdef SRAM_LIKE_ARB_RR_EN
        exp_grants = 4'b0101;
`else
        exp_grants = 4'b1111;
`endif
        chk("t3_grant_order", {28'd0, grants}, {28'd0, exp_grants});

        // Master stalls addr_ok for 5 cycles
        set_inst(1'b1, 32'hBFC00040); set_data(1'b0, 1'b0, 32'h0, 32'h0);
        set_m(1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t4_m_addr_stable", obs_maddr, 32'hBFC00040);
            chk("t4_busy_low", {31'd0, obs_busy}, 32'd0);
        end
        set_m(1'b1, 1'b0, 32'h0);
        cycle();
        chk("t4_accept_c6", {31'd0, obs_iaok}, 32'd1);
        set_inst(1'b0, 32'h0); set_m(1'b0, 1'b1, 32'h0);
        cycle();

        // Spurious data_ok in IDLE
        set_m(1'b0, 1'b1, 32'h12345678);
        cycle();
        chk("t5_idle_inst_dok", {31'd0, obs_idok}, 32'd0);
        chk("t5_idle_data_dok", {31'd0, obs_ddok}, 32'd0);
        set_m(1'b0, 1'b0, 32'h0);
        cycle();
        chk("t5_still_idle", {31'd0, obs_busy}, 32'd0);

        // Reset during WAIT with data as owner
        set_data(1'b1, 1'b0, 32'h80000100, 32'h0); set_m(1'b1, 1'b0, 32'h0);
        cycle();
        set_m(1'b0, 1'b0, 32'h0);
        #1 rst = 1'b1;
        #1;
        chk("t6_busy_async", {31'd0, busy}, 32'd0);
        pend = -1; last = 0;
        cycle();
        rst = 1'b0;
        set_data(1'b0, 1'b0, 32'h0, 32'h0); set_m(1'b0, 1'b1, 32'hCAFEF00D);
        cycle();
        chk("t6_dropped_dok", {31'd0, obs_ddok}, 32'd0);
        set_inst(1'b1, 32'hBFC00080); set_m(1'b1, 1'b0, 32'h0);
        cycle();
        chk("t6_inst_accept", {31'd0, obs_iaok}, 32'd1);
        set_inst(1'b0, 32'h0); set_m(1'b0, 1'b1, 32'h0);
        cycle();

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 63) == 0);
            inst_bus.req = $urandom_range(0, 1); inst_bus.wr = $urandom_range(0, 1);
            inst_bus.size = 2'($urandom_range(0, 2)); inst_bus.addr = $urandom; inst_bus.wdata = $urandom;
            data_bus.req = $urandom_range(0, 1); data_bus.wr = $urandom_range(0, 1);
            data_bus.size = 2'($urandom_range(0, 2)); data_bus.addr = $urandom; data_bus.wdata = $urandom;
            set_m(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
